// File: rtl/ysyx_22040125_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, default reset PC / NOP word and a PC helper.
package ysyx_22040125_ifu_pkg;

    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_REQ   = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_HOLD  = 3'd3,
        IFU_DRAIN = 3'd4
    } ifu_state_e;

    function automatic logic pc_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22040125_ifu_if.sv
// Fetch-unit bus: imem request/response channel plus the inst channel to decode.
// master = IFU side (drives req and inst), slave = memory/decode side.
interface ysyx_22040125_ifu_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready
    );

endinterface

// File: rtl/ysyx_22040125_ifu_pc.sv
// PC register with next-pc select: redirect_pc > pc+4 (advance) > hold.
// Ports: clk, rst_n, redirect_valid/redirect_pc, advance in; pc out.
module ysyx_22040125_ifu_pc
    import ysyx_22040125_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        advance,
    output logic [63:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + 64'd4;
        end
    end

endmodule

// File: rtl/ysyx_22040125_ifu.sv
// Instruction fetch unit: owns the PC, fetches from imem, buffers one inst to decode.
// Ports: clk, rst_n, redirect_valid/redirect_pc from execute, bus (imem + inst channels).
module ysyx_22040125_ifu
    import ysyx_22040125_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    ysyx_22040125_ifu_if.master      bus
);

    ifu_state_e  state_q;
    ifu_state_e  state_d;
    logic [63:0] pc;
    logic [31:0] inst_q;
    logic [63:0] inst_pc_q;
    logic        fault_q;
    logic        load;
    logic [31:0] load_inst;
    logic        load_fault;
    logic        req_fire;
    logic        deliver;
    logic        holding;

    // Outputs are decoded from registered state only.
    assign holding            = state_q == IFU_HOLD;
    assign bus.imem_req_valid = (state_q == IFU_REQ) && !pc_misaligned(pc);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = holding;
    assign bus.inst           = holding ? inst_q : NOP_INST;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_fault     = holding && fault_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign deliver  = holding && bus.inst_ready;

    ysyx_22040125_ifu_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (deliver),
        .pc             (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IFU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_inst  = NOP_INST;
        load_fault = 1'b0;
        unique case (state_q)
            IFU_IDLE: state_d = IFU_REQ;
            IFU_REQ: begin
                if (redirect_valid) begin
                    // An accepted request still owes a response: drain it.
                    state_d = req_fire ? IFU_DRAIN : IFU_REQ;
                end else if (pc_misaligned(pc)) begin
                    load       = 1'b1;
                    load_fault = 1'b1;
                    state_d    = IFU_HOLD;
                end else if (req_fire) begin
                    state_d = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    state_d = bus.imem_resp_valid ? IFU_REQ : IFU_DRAIN;
                end else if (bus.imem_resp_valid) begin
                    load       = 1'b1;
                    load_inst  = bus.imem_resp_data;
                    load_fault = bus.imem_resp_err;
                    state_d    = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (redirect_valid || bus.inst_ready) begin
                    state_d = IFU_REQ;
                end
            end
            IFU_DRAIN: begin
                if (bus.imem_resp_valid) begin
                    state_d = IFU_REQ;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
            fault_q   <= 1'b0;
        end else if (load) begin
            inst_q    <= load_inst;
            inst_pc_q <= pc;
            fault_q   <= load_fault;
        end
    end

endmodule
